// File: rtl/trap_ctrl_pkg.sv
// Shared PC-select codes, trap vectors and small helpers for the trap controller.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ = 3'b000,
    PCSRC_BR  = 3'b001,
    PCSRC_J   = 3'b010,
    PCSRC_JR  = 3'b011,
    PCSRC_IRQ = 3'b100,
    PCSRC_EXC = 3'b101
  } pcsrc_e;

  localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC = 32'h8000_0008;

  // Kernel mode is the upper half of the address space.
  function automatic logic is_kernel(input logic [31:0] pc);
    return pc[31];
  endfunction

  // Return address of the following instruction, wrapping mod 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Control-decode side of the trap controller: decoder inputs and PC/EPC outputs.
interface trap_ctrl_if;
  logic [31:0] pc;
  logic [2:0]  dec_pcsrc;
  logic        illop;
  logic [2:0]  pcsrc;
  logic [31:0] epc;
  logic        epc_we;
  logic        squash;

  modport master (
    output pc, dec_pcsrc, illop,
    input  pcsrc, epc, epc_we, squash
  );

  modport slave (
    input  pc, dec_pcsrc, illop,
    output pcsrc, epc, epc_we, squash
  );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Synchronizes the asynchronous timer IRQ and flags its rising edge for one cycle.
module trap_ctrl_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic irq_rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one delayed copy of its output for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r[0] <= irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign irq_rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: merges decoder next-PC select with timer IRQ and illegal-opcode traps.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  trap_ctrl_if.slave       bus,
  input  logic             irq,
  output logic             irq_ack,
  output logic             double_fault,
  output logic [CNT_W-1:0] irq_cnt,
  output logic [CNT_W-1:0] exc_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             irq_rise_s;
  logic             irq_pend_r;
  logic             double_fault_r;
  logic [CNT_W-1:0] irq_cnt_r;
  logic [CNT_W-1:0] exc_cnt_r;

  logic [2:0]       pcsrc_s;
  logic [31:0]      epc_s;
  logic             epc_we_s;
  logic             squash_s;
  logic             irq_ack_s;
  logic             take_exc_s;
  logic             take_irq_s;
  logic             set_df_s;

  trap_ctrl_irq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .irq_rise (irq_rise_s)
  );

  // Priority decision: exception over interrupt over the decoder's own select.
  // Decisions are zero-latency; reset is folded in so nothing is taken while held.
  always_comb begin
    pcsrc_s    = PCSRC_SEQ;
    epc_s      = pc_plus4(bus.pc);
    epc_we_s   = 1'b0;
    squash_s   = 1'b0;
    irq_ack_s  = 1'b0;
    take_exc_s = 1'b0;
    take_irq_s = 1'b0;
    set_df_s   = 1'b0;
    if (!reset) begin
      pcsrc_s = PCSRC_SEQ;
    end else if (bus.illop) begin
      pcsrc_s    = PCSRC_EXC;
      squash_s   = 1'b1;
      take_exc_s = 1'b1;
      // A fault inside the handler must not overwrite the EPC of the first trap.
      if (is_kernel(bus.pc)) begin
        set_df_s = 1'b1;
      end else begin
        epc_we_s = 1'b1;
      end
    end else if (irq_pend_r && !is_kernel(bus.pc)) begin
      // EPC is the interrupted instruction itself so jr $26 re-executes it.
      pcsrc_s    = PCSRC_IRQ;
      epc_s      = bus.pc;
      epc_we_s   = 1'b1;
      squash_s   = 1'b1;
      irq_ack_s  = 1'b1;
      take_irq_s = 1'b1;
    end else begin
      pcsrc_s = bus.dec_pcsrc;
    end
  end

  // Pending IRQ, sticky double-fault flag and wrapping event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pend_r     <= 1'b0;
      double_fault_r <= 1'b0;
      irq_cnt_r      <= {CNT_W{1'b0}};
      exc_cnt_r      <= {CNT_W{1'b0}};
    end else begin
      irq_pend_r <= (irq_pend_r & ~take_irq_s) | irq_rise_s;
      if (set_df_s) begin
        double_fault_r <= 1'b1;
      end
      if (take_exc_s) begin
        exc_cnt_r <= exc_cnt_r + CNT_ONE;
      end
      if (take_irq_s) begin
        irq_cnt_r <= irq_cnt_r + CNT_ONE;
      end
    end
  end

  assign bus.pcsrc    = pcsrc_s;
  assign bus.epc      = epc_s;
  assign bus.epc_we   = epc_we_s;
  assign bus.squash   = squash_s;
  assign irq_ack      = irq_ack_s;
  assign double_fault = double_fault_r;
  assign irq_cnt      = irq_cnt_r;
  assign exc_cnt      = exc_cnt_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a reference model feeding a scoreboard queue.
module tb_trap_ctrl;

  localparam int S = 2;

  typedef struct {
    logic [2:0]  pcsrc;
    logic [31:0] epc;
    logic        epc_chk;
    logic        epc_we;
    logic        squash;
    logic        ack;
    logic        df;
    logic [15:0] icnt;
    logic [15:0] ecnt;
  } exp_t;

  logic        clk;
  logic        reset_v;
  logic        irq_v;
  logic        irq_ack;
  logic        df;
  logic [15:0] irq_cnt;
  logic [15:0] exc_cnt;

  trap_ctrl_if bus ();

  trap_ctrl #(.SYNC_STAGES(S), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset_v),
    .bus          (bus),
    .irq          (irq_v),
    .irq_ack      (irq_ack),
    .double_fault (df),
    .irq_cnt      (irq_cnt),
    .exc_cnt      (exc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  exp_t sb_q[$];

  // Reference model state
  logic [S-1:0] m_sync;
  logic         m_prev;
  logic         m_pend;
  logic         m_df;
  logic [15:0]  m_icnt;
  logic [15:0]  m_ecnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = '0; m_prev = 1'b0; m_pend = 1'b0; m_df = 1'b0; m_icnt = 16'd0; m_ecnt = 16'd0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.pcsrc = bus.dec_pcsrc; e.epc = bus.pc + 32'd4; e.epc_chk = 1'b1;
    e.epc_we = 1'b0; e.squash = 1'b0; e.ack = 1'b0;
    e.df = m_df; e.icnt = m_icnt; e.ecnt = m_ecnt;
    if (!reset_v) begin
      e.pcsrc = 3'b000; e.epc_chk = 1'b0;
    end else if (bus.illop) begin
      e.pcsrc = 3'b101; e.squash = 1'b1;
      if (bus.pc[31]) e.epc_chk = 1'b0;
      else e.epc_we = 1'b1;
    end else if (m_pend && !bus.pc[31]) begin
      e.pcsrc = 3'b100; e.epc = bus.pc; e.epc_we = 1'b1; e.squash = 1'b1; e.ack = 1'b1;
    end
    return e;
  endfunction

  task automatic model_edge();
    logic take;
    logic rise;
    if (!reset_v) begin
      model_reset();
    end else begin
      take = !bus.illop && m_pend && !bus.pc[31];
      rise = m_sync[S-1] & ~m_prev;
      m_prev = m_sync[S-1];
      for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = irq_v;
      m_pend = (m_pend & ~take) | rise;
      if (bus.illop) begin
        m_ecnt = m_ecnt + 16'd1;
        if (bus.pc[31]) m_df = 1'b1;
      end
      if (take) m_icnt = m_icnt + 16'd1;
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    chk({tag, ".pcsrc"}, {29'd0, bus.pcsrc}, {29'd0, e.pcsrc});
    if (e.epc_chk) chk({tag, ".epc"}, bus.epc, e.epc);
    chk({tag, ".epc_we"}, {31'd0, bus.epc_we}, {31'd0, e.epc_we});
    chk({tag, ".squash"}, {31'd0, bus.squash}, {31'd0, e.squash});
    chk({tag, ".irq_ack"}, {31'd0, irq_ack}, {31'd0, e.ack});
    chk({tag, ".dfault"}, {31'd0, df}, {31'd0, e.df});
    chk({tag, ".irq_cnt"}, {16'd0, irq_cnt}, {16'd0, e.icnt});
    chk({tag, ".exc_cnt"}, {16'd0, exc_cnt}, {16'd0, e.ecnt});
  endtask

  // want[3]=1 adds an independent literal check of pcsrc against want[2:0].
  task automatic step(input string tag, input logic [31:0] pc, input logic [2:0] dec,
                      input logic il, input logic iq, input logic [3:0] want);
    bus.pc = pc; bus.dec_pcsrc = dec; bus.illop = il; irq_v = iq;
    sb_q.push_back(predict());
    @(negedge clk);
    check_out(tag);
    if (want[3]) chk({tag, ".lit"}, {29'd0, bus.pcsrc}, {29'd0, want[2:0]});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    reset_v = 1'b0; irq_v = 1'b1;
    bus.pc = 32'h0000_0040; bus.dec_pcsrc = 3'b001; bus.illop = 1'b1;
    @(posedge clk); #1;
    // Reset held with irq and illop active
    step("rst0", 32'h0000_0040, 3'b001, 1'b1, 1'b1, 4'b1000);
    step("rst1", 32'h0000_0040, 3'b001, 1'b1, 1'b1, 4'b1000);
    reset_v = 1'b1;
    step("idle0", 32'h0000_0040, 3'b000, 1'b0, 1'b0, 4'b1000);
    step("idle1", 32'h0000_0040, 3'b010, 1'b0, 1'b0, 4'b1010);
    // IRQ in user mode: taken after S+1 edges
    step("irq_s1", 32'h0000_0040, 3'b000, 1'b0, 1'b1, 4'b1000);
    step("irq_s2", 32'h0000_0040, 3'b000, 1'b0, 1'b1, 4'b1000);
    step("irq_s3", 32'h0000_0040, 3'b000, 1'b0, 1'b1, 4'b1000);
    step("irq_tk", 32'h0000_0040, 3'b000, 1'b0, 1'b1, 4'b1100);
    step("irq_aft", 32'h8000_0004, 3'b000, 1'b0, 1'b1, 4'b1000);
    step("irq_lo0", 32'h8000_0008, 3'b000, 1'b0, 1'b0, 4'b1000);
    step("irq_lo1", 32'h8000_000C, 3'b000, 1'b0, 1'b0, 4'b1000);
    step("irq_lo2", 32'h8000_000C, 3'b000, 1'b0, 1'b0, 4'b1000);
    // Masked while in kernel mode, taken at first user pc
    for (int i = 0; i < 5; i++)
      step("kmask", 32'h8000_0010, 3'b011, 1'b0, 1'b1, 4'b1011);
    step("kmask_tk", 32'h0000_0044, 3'b000, 1'b0, 1'b0, 4'b1100);
    step("kmask_aft", 32'h0000_0044, 3'b000, 1'b0, 1'b0, 4'b1000);
    // Illegal opcode in user mode
    step("ill_usr", 32'h0000_0100, 3'b000, 1'b1, 1'b0, 4'b1101);
    step("ill_aft", 32'h8000_0008, 3'b000, 1'b0, 1'b0, 4'b1000);
    // Collision: exception wins, pending IRQ survives kernel stretch
    for (int i = 0; i < 4; i++)
      step("col_arm", 32'h8000_0030, 3'b000, 1'b0, 1'b1, 4'b1000);
    step("col_ill", 32'h0000_0200, 3'b000, 1'b1, 1'b0, 4'b1101);
    step("col_krn", 32'h8000_0008, 3'b000, 1'b0, 1'b0, 4'b1000);
    step("col_irq", 32'h0000_0204, 3'b000, 1'b0, 1'b0, 4'b1100);
    // pc+4 wraps mod 2^32; unusual decoder codes pass through
    step("wrap", 32'hFFFF_FFFC, 3'b001, 1'b0, 1'b0, 4'b1001);
    step("dec110", 32'h0000_0300, 3'b110, 1'b0, 1'b0, 4'b1110);
    step("dec111", 32'h0000_0304, 3'b111, 1'b0, 1'b0, 4'b1111);
    // Double fault in kernel mode is sticky
    step("dbl", 32'h8000_0020, 3'b000, 1'b1, 1'b0, 4'b1101);
    step("dbl_h0", 32'h8000_0024, 3'b000, 1'b0, 1'b0, 4'b1000);
    step("dbl_h1", 32'h0000_0400, 3'b011, 1'b0, 1'b0, 4'b1011);
    // Asynchronous reset mid-cycle drops all state at once
    bus.pc = 32'h8000_0040; bus.illop = 1'b0; bus.dec_pcsrc = 3'b010;
    #2 reset_v = 1'b0;
    #1;
    model_reset();
    chk("arst.dfault", {31'd0, df}, 32'd0);
    chk("arst.irq_cnt", {16'd0, irq_cnt}, 32'd0);
    chk("arst.exc_cnt", {16'd0, exc_cnt}, 32'd0);
    chk("arst.pcsrc", {29'd0, bus.pcsrc}, 32'd0);
    @(posedge clk); #1;
    reset_v = 1'b1;
    step("post_rst", 32'h0000_0500, 3'b001, 1'b0, 1'b0, 4'b1001);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
